// File: rtl/imm_encoder.sv
// imm_encoder: packs a signed immediate into instruction bits [31:7] in
// I/S/B/J layout and flags immediates that do not fit the selected format.
// The block is a two-stage valid/ready pipeline:
//   stage 1 registers the inputs and the range check;
//   stage 2 registers the packed instruction.
// Optional feature: define IMM_ENC_STATS_EN to build saturating
// delivered-beat and error-beat counters. When it is undefined,
// enc_count and err_count are tied to 0.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      imm,
  input  logic [1:0]       immsrc,
  input  logic [24:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      instr,
  output logic             range_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {FMT_I = 2'b00, FMT_S = 2'b01, FMT_B = 2'b10, FMT_J = 2'b11} fmt_e;

  // Valid bits: [0] is stage 1 (check), [1] is stage 2 (pack).
  logic [1:0]  vld_q, vld_d;

  // Stage-1 payload. Only imm[20:0] is kept, because the pack stage
  // never reads above bit 20. The range check already consumed the
  // upper bits.
  logic [20:0] s1_imm_q, s1_imm_d;
  logic [1:0]  s1_src_q, s1_src_d;
  logic [24:0] s1_base_q, s1_base_d;
  logic        s1_err_q, s1_err_d;

  // Stage-2 payload (drives the outputs directly).
  logic [24:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q, s2_err_d;

  logic        rdy1, rdy2;

  // An immediate fits when the bits above the format's top bit are all
  // sign copies. B and J also need 2-byte alignment.
  function automatic logic imm_bad(input logic [31:0] v, input logic [1:0] src);
    logic bad;
    bad = 1'b0;
    case (fmt_e'(src))
      FMT_I, FMT_S: bad = !((&v[31:11]) || !(|v[31:11]));
      FMT_B:        bad = !((&v[31:12]) || !(|v[31:12])) || v[0];
      FMT_J:        bad = !((&v[31:20]) || !(|v[31:20])) || v[0];
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Scatter the immediate into bits [31:7]. Vector index = instr bit - 7.
  function automatic logic [24:0] pack(input logic [20:0] v, input logic [1:0] src,
                                       input logic [24:0] b);
    logic [24:0] p;
    p = b;
    case (fmt_e'(src))
      FMT_I: p[24:13] = v[11:0];
      FMT_S: begin
        p[24:18] = v[11:5];
        p[4:0]   = v[4:0];
      end
      FMT_B: begin
        p[24]    = v[12];
        p[23:18] = v[10:5];
        p[4:1]   = v[4:1];
        p[0]     = v[11];
      end
      FMT_J: begin
        p[24]    = v[20];
        p[23:14] = v[10:1];
        p[13]    = v[11];
        p[12:5]  = v[19:12];
      end
      default: p = b;
    endcase
    return p;
  endfunction

  // Ready chain: a stage loads when it is empty or its beat leaves this cycle.
  always_comb begin
    rdy2     = !vld_q[1] || out_ready;
    rdy1     = !vld_q[0] || rdy2;
    in_ready = rdy1;
  end

  // Next-state for both stages. Payloads only move with a real beat, so
  // a stalled output holds its values.
  always_comb begin
    vld_d      = vld_q;
    s1_imm_d   = s1_imm_q;
    s1_src_d   = s1_src_q;
    s1_base_d  = s1_base_q;
    s1_err_d   = s1_err_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (rdy1) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        s1_imm_d  = imm[20:0];
        s1_src_d  = immsrc;
        s1_base_d = base;
        s1_err_d  = imm_bad(imm, immsrc);
      end
    end
    if (rdy2) begin
      vld_d[1] = vld_q[0];
      if (vld_q[0]) begin
        s2_instr_d = pack(s1_imm_q, s1_src_q, s1_base_q);
        s2_err_d   = s1_err_q;
      end
    end
  end

  // Pipeline state register. Reset drops every in-flight beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q      <= '0;
      s1_imm_q   <= '0;
      s1_src_q   <= '0;
      s1_base_q  <= '0;
      s1_err_q   <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      s1_imm_q   <= s1_imm_d;
      s1_src_q   <= s1_src_d;
      s1_base_q  <= s1_base_d;
      s1_err_q   <= s1_err_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid = vld_q[1];
  assign instr     = s2_instr_q;
  assign range_err = s2_err_q;

`ifdef IMM_ENC_STATS_EN
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;
  logic             out_hs;

  // Saturating counters that advance on each delivered beat.
  always_comb begin
    out_hs    = vld_q[1] && out_ready;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (out_hs && !(&enc_cnt_q))             enc_cnt_d = enc_cnt_q + 1'b1;
    if (out_hs && s2_err_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign enc_count = '0;
  assign err_count = '0;
`endif

endmodule
